// File: rtl/clk_tick_rx.sv
// clk_tick_rx: turns a slow (~100 Hz) square wave into single-cycle ticks in the
// clk_ht domain, supervises it with a watchdog and divides ticks into game steps.
// Optional feature macro: TICK_BOTH_EDGES_EN (count falling edges as well).
module clk_tick_rx #(
    parameter int unsigned WD_LIMIT = 1100000,
    parameter int unsigned WD_W     = 21
) (
    input  logic       clk_ht,
    input  logic       rst_n,
    input  logic       clk_slow,
    input  logic [7:0] step_div,
    output logic       tick,
    output logic       step,
    output logic       locked,
    output logic       lost
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_LOST   = 2'd2;

    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WD_LIMIT);
    localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

    logic            s1, s2, s3;
    logic            slow_edge;
    logic [1:0]      state, state_nxt;
    logic [WD_W-1:0] wd_cnt, wd_nxt, wd_inc;
    logic [7:0]      step_cnt, step_nxt;
    logic [7:0]      eff_div;
    logic [8:0]      cnt_inc;
    logic            step_fire;

`ifdef TICK_BOTH_EDGES_EN
    assign slow_edge = s2 ^ s3;
`else
    assign slow_edge = s2 & ~s3;
`endif

    assign locked = (state == ST_LOCKED);
    assign lost   = (state == ST_LOST);

    // Next-state logic: FSM, watchdog supervision and step division
    always_comb begin
        state_nxt = state;
        wd_nxt    = wd_cnt;
        step_nxt  = step_cnt;
        step_fire = 1'b0;
        eff_div   = (step_div == 8'd0) ? 8'd1 : step_div;
        cnt_inc   = {1'b0, step_cnt} + 9'd1;
        wd_inc    = wd_cnt + WD_ONE;

        case (state)
            ST_SEARCH: begin
                wd_nxt = '0;
                if (slow_edge) begin
                    state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (slow_edge) begin
                    wd_nxt = '0;
                end else if (wd_inc >= WD_MAX) begin
                    state_nxt = ST_LOST;
                    wd_nxt    = WD_MAX;
                    step_nxt  = 8'd0;
                end else begin
                    wd_nxt = wd_inc;
                end
            end
            ST_LOST: begin
                if (slow_edge) begin
                    state_nxt = ST_LOCKED;
                    wd_nxt    = '0;
                end else begin
                    wd_nxt = WD_MAX;
                end
            end
            default: begin
                state_nxt = ST_SEARCH;
                wd_nxt    = '0;
                step_nxt  = 8'd0;
            end
        endcase

        // The >= compare keeps a lowered step_div from stranding the count
        if (slow_edge && (state_nxt == ST_LOCKED)) begin
            if (cnt_inc >= {1'b0, eff_div}) begin
                step_fire = 1'b1;
                step_nxt  = 8'd0;
            end else begin
                step_nxt = cnt_inc[7:0];
            end
        end
    end

    // Synchronizer, state registers and registered pulse outputs
    always_ff @(posedge clk_ht) begin
        if (!rst_n) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            state    <= ST_SEARCH;
            wd_cnt   <= '0;
            step_cnt <= 8'd0;
            tick     <= 1'b0;
            step     <= 1'b0;
        end else begin
            s1       <= clk_slow;
            s2       <= s1;
            s3       <= s2;
            state    <= state_nxt;
            wd_cnt   <= wd_nxt;
            step_cnt <= step_nxt;
            tick     <= slow_edge;
            step     <= step_fire;
        end
    end

endmodule
